// File: rtl/dice_roller_multi.sv
// rtl/dice_roller_multi.sv - multi-die electronic dice roller with tumble and result pulse
//
// Purpose: NUM_DICE dice, each counting 1..FACES, advance as an odometer
// while the button is held and for SETTLE_CYCLES more steps after release.
// On settling, valid pulses for one cycle with the final throw.
//
// Optional feature macro: DICE_ROLL_COUNT_EN (adds 16-bit roll_count output).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   button     debounced roll request
//   throw      packed die values, die i at throw[i*W +: W]
//   sum        sum of all die values
//   doubles    all dice equal
//   busy       rolling or settling
//   valid      one-cycle result-final pulse
//   roll_count completed rolls, saturating (DICE_ROLL_COUNT_EN only)

module dice_roller_multi #(
  parameter int NUM_DICE      = 2,
  parameter int FACES         = 6,
  parameter int SETTLE_CYCLES = 3,
  localparam int W  = $clog2(FACES + 1),
  localparam int SW = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  output logic [NUM_DICE*W-1:0] throw,
  output logic [SW-1:0]         sum,
  output logic                  doubles,
  output logic                  busy,
  output logic                  valid
`ifdef DICE_ROLL_COUNT_EN
  ,
  output logic [15:0]           roll_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [7:0]          cnt, cnt_nx;
  logic                adv;
  logic                valid_nx;
  logic [W-1:0]        dice [NUM_DICE];
  logic [NUM_DICE-1:0] carry;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    adv      = 1'b0;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        // Entering ROLLING does not advance; the first step is on the next edge.
        if (button) state_nx = ROLLING;
      end
      ROLLING: begin
        adv = 1'b1;
        if (!button) begin
          state_nx = SETTLE;
          cnt_nx   = 8'(SETTLE_CYCLES);
        end
      end
      SETTLE: begin
        adv    = 1'b1;
        cnt_nx = cnt - 8'd1;
        // Treat an unexpected zero count as the final step so SETTLE cannot stick.
        if (cnt <= 8'd1) begin
          cnt_nx   = 8'd0;
          state_nx = IDLE;
          valid_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Odometer carry: die i steps only when every lower die wraps this edge.
  always_comb begin
    carry    = '0;
    carry[0] = adv;
    for (int i = 1; i < NUM_DICE; i++) begin
      carry[i] = carry[i-1] && (dice[i-1] == W'(FACES));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_DICE; i++) dice[i] <= W'(1);
    end else begin
      for (int i = 0; i < NUM_DICE; i++) begin
        if (carry[i]) begin
          dice[i] <= (dice[i] == W'(FACES)) ? W'(1) : dice[i] + W'(1);
        end
      end
    end
  end

  always_comb begin
    throw   = '0;
    sum     = '0;
    doubles = 1'b1;
    for (int i = 0; i < NUM_DICE; i++) begin
      throw[i*W +: W] = dice[i];
      sum             = sum + SW'(dice[i]);
      if (dice[i] != dice[0]) doubles = 1'b0;
    end
  end

  assign busy = (state != IDLE);

`ifdef DICE_ROLL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      roll_count <= 16'd0;
    end else if (valid_nx && (roll_count != 16'hFFFF)) begin
      roll_count <= roll_count + 16'd1;
    end
  end
`else
  // No roll counter in this build.
`endif

endmodule

// File: doc/dice_roller_multi.md
Name: dice_roller_multi

Overview:
- Parametrised successor to the single 3-bit electronic die: NUM_DICE independent dice, each with FACES faces (values 1..FACES).
- Dice cycle while the button is held, then run for SETTLE_CYCLES more steps after release ("tumble").
- On settling, the block presents a one-cycle result pulse with the per-die values, their sum and a doubles flag.
- Sits between a debounced button input and a display/scoring block.

Parameters:
- NUM_DICE, 2, number of dice (1..8).
- FACES, 6, faces per die (2..255).
- SETTLE_CYCLES, 3, advance steps after button release (1..255).
- Derived (localparam, not overridable): W = $clog2(FACES+1); SW = $clog2(NUM_DICE*FACES+1).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
- button  input  1  roll request, already debounced and synchronous to clk.
- throw  output  NUM_DICE*W  packed die values; die i at throw[i*W +: W].
- sum  output  SW  arithmetic sum of all die values.
- doubles  output  1  1 when all dice hold equal values (always 1 when NUM_DICE=1).
- busy  output  1  1 while rolling or settling.
- valid  output  1  one-cycle pulse: result final.

Behaviour:
- Reset (rst=0 at an edge): every die = 1, state IDLE, valid=0, settle counter=0. Reset overrides all other activity, including mid-ROLLING and mid-SETTLE; no valid pulse follows a reset.
- Die values are always in 1..FACES; 0 and values above FACES are never output.
- State machine, evaluated on the registered state before each edge:
  - IDLE: button=1 moves to ROLLING; no advance on that edge. button=0 stays IDLE.
  - ROLLING: advance on every edge. button=0 moves to SETTLE and loads the settle counter with SETTLE_CYCLES. button=1 stays ROLLING.
  - SETTLE: advance on every edge and decrement the counter; button is ignored. On the edge where the counter goes 1→0, move to IDLE and set valid=1 for exactly the following cycle.
- Advance rule (odometer):
  - die 0 steps +1 and wraps FACES→1.
  - die i (i>0) steps only on the same edge that every die 0..i-1 wraps.
  - The last die wraps without carry-out.
- Combinational outputs:
  - sum = zero-extended sum of the throw fields; always consistent with throw in the same cycle.
  - doubles: all fields equal.
  - busy = (state != IDLE).
  - Both are valid in every cycle, but downstream consumes them only with valid.
- Boundary cases:
  - valid cycle with button=1: IDLE→ROLLING proceeds normally; the valid pulse is not suppressed.
  - throw holds its last value in IDLE indefinitely.
  - button held any length: wrap-around is continuous; no saturation.

Optional Feature:
- Macro: DICE_ROLL_COUNT_EN.
- Defined: adds output roll_count (16 bits), reset to 0.
  - Increments by 1 on each edge that raises valid.
  - Saturates at 16'hFFFF.
  - Reset by rst like all other state.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults (NUM_DICE=2, FACES=6, SETTLE_CYCLES=3) throughout.
- Reset: rst=0 for 2 edges → throw die0=1, die1=1; sum=2; doubles=1; busy=0; valid=0.
- button=1 sampled at edges 1–5, 0 from edge 6 → 8 advances (edges 2–9). Required: busy=1 from edge 1, valid=1 only in the cycle after edge 9, die0=3, die1=2, sum=5, doubles=0.
- button=1 at edges 1–4, 0 from edge 5 → 7 advances. Required: die0=2, die1=2, sum=4, doubles=1, valid pulse after edge 8.
- button=1 at edges 1–33, 0 from edge 34 → 36 advances. Required: die0=1, die1=1 (full wrap), sum=2, valid pulse after edge 37.
- Repeat the 8-advance scenario with button toggled 1/0 during SETTLE → identical result (3,2). Repeat again with rst=0 at edge 8 → throw=(1,1), busy=0, and no valid pulse ever.
- With DICE_ROLL_COUNT_EN defined: three complete rolls → roll_count=3; assert rst → 0.
